// File: rtl/mx_blk_unpack.sv
// MX block unpacker: holds one block (shared scale + narrow sign-magnitude elements)
// and streams each element as a normalised, left-aligned wide mantissa with its own exponent.
module mx_blk_unpack #(
  parameter int block_size = 32,
  parameter int width_i    = 4,
  parameter int width_o    = 24,
  parameter int width_e    = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [block_size*(width_i+1)-1:0]     i_blk,
  input  logic [width_e-1:0]                    i_scl,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  output logic                                  o_sgn,
  output logic [width_o-1:0]                    o_man,
  output logic [width_e+1:0]                    o_exp,
  output logic                                  o_zero,
  output logic [$clog2(block_size)-1:0]         o_idx,
  output logic                                  o_last,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_dbg_state
);

  localparam int ew  = width_i + 1;
  localparam int iw  = $clog2(block_size);
  localparam int lzw = $clog2(width_i + 1);
  localparam int bw  = block_size * ew;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t            state_q;
  logic [bw-1:0]     blk_q;
  logic [width_e-1:0] scl_q;
  logic [iw-1:0]     idx_q;

  logic              emit;
  logic              at_last;
  logic              take_blk;
  logic [ew-1:0]     elem;
  logic [width_i-1:0] mag;
  logic [width_i-1:0] norm;
  logic [lzw-1:0]    lzc;
  logic              found;
  logic              mag_zero;
  logic [width_o-1:0] man_w;

  // Handshakes (valid/ready): a transfer happens on a rising clock edge where valid and
  // ready are both high. o_ready depends combinationally only on i_ready (last-element
  // transfer) and is forced low while reset is asserted; o_valid is purely registered.
  assign emit     = (state_q == EMIT);
  assign at_last  = (idx_q == iw'(block_size - 1));
  assign o_ready  = !i_rst && (emit ? (i_ready && at_last) : 1'b1);
  assign take_blk = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      blk_q   <= '0;
      scl_q   <= '0;
    end else if (take_blk) begin
      // Covers both IDLE acceptance and the zero-bubble reload on the last transfer.
      state_q <= EMIT;
      idx_q   <= '0;
      blk_q   <= i_blk;
      scl_q   <= i_scl;
    end else if (emit && i_ready) begin
      if (at_last) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + iw'(1);
      end
    end
  end

  always_comb begin
    elem  = ew'(blk_q >> (32'(idx_q) * ew));
    mag   = elem[width_i-1:0];
    lzc   = '0;
    found = 1'b0;
    for (int b = width_i - 1; b >= 0; b--) begin
      if (!found) begin
        if (mag[b]) found = 1'b1;
        else        lzc   = lzc + lzw'(1);
      end
    end
    norm  = mag << lzc;
    man_w = width_o'(norm) << (width_o - width_i);
  end

  assign mag_zero    = (mag == '0);
  assign o_valid     = emit;
  assign o_dbg_state = emit;
  assign o_sgn       = emit && elem[width_i];
  assign o_zero      = emit && mag_zero;
  assign o_idx       = emit ? idx_q : '0;
  assign o_last      = emit && at_last;
  assign o_man       = (emit && !mag_zero) ? man_w : '0;
  // Two guard bits keep scale 0 minus a full leading-zero count negative instead of wrapping.
  assign o_exp       = (emit && !mag_zero) ? ({2'b00, scl_q} - (width_e + 2)'(lzc)) : '0;

endmodule

// File: tb/tb_mx_blk_unpack.sv
// Bench for mx_blk_unpack: directed cases from the block's behaviour plus randomized
// blocks, with a scoreboard queue filled at block acceptance and drained by a monitor.
module tb_mx_blk_unpack;

  localparam int BS = 4;
  localparam int WI = 4;
  localparam int WO = 8;
  localparam int WE = 8;
  localparam int IW = 2;
  localparam int EW = WE + 2;
  localparam int BW = BS * (WI + 1);
  localparam int RW = 1 + WO + EW + 1 + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst     = 1'b1;
  logic [BW-1:0]  i_blk   = '0;
  logic [WE-1:0]  i_scl   = '0;
  logic           i_valid = 1'b0;
  logic           i_ready = 1'b0;
  logic           o_ready;
  logic           o_sgn;
  logic [WO-1:0]  o_man;
  logic [EW-1:0]  o_exp;
  logic           o_zero;
  logic [IW-1:0]  o_idx;
  logic           o_last;
  logic           o_valid;
  logic           o_dbg_state;

  mx_blk_unpack #(.block_size(BS), .width_i(WI), .width_o(WO), .width_e(WE)) dut (
    .i_clk(clk), .i_rst(rst), .i_blk(i_blk), .i_scl(i_scl), .i_valid(i_valid),
    .o_ready(o_ready), .o_sgn(o_sgn), .o_man(o_man), .o_exp(o_exp), .o_zero(o_zero),
    .o_idx(o_idx), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] mk(input logic sgn, input logic [WO-1:0] man,
                                       input logic [EW-1:0] ex, input logic z,
                                       input logic [IW-1:0] idx, input logic last);
    return {sgn, man, ex, z, idx, last};
  endfunction

  function automatic logic [RW-1:0] model(input logic [WI:0] e, input int scl, input int idx);
    int mag;
    int lz;
    logic [WO-1:0] man;
    logic [EW-1:0] ex;
    logic z;
    mag = int'(e[WI-1:0]);
    if (mag == 0) begin
      man = '0; ex = '0; z = 1'b1;
    end else begin
      lz = 0;
      while (mag < (1 << (WI - 1))) begin
        mag = mag * 2;
        lz++;
      end
      man = WO'(mag * (1 << (WO - WI)));
      ex  = EW'(scl - lz);
      z   = 1'b0;
    end
    return mk(e[WI], man, ex, z, IW'(idx), idx == BS - 1);
  endfunction

  task automatic push_model(input logic [BW-1:0] blk, input logic [WE-1:0] scl);
    logic [WI:0] e;
    for (int k = 0; k < BS; k++) begin
      e = blk[k*(WI+1) +: WI+1];
      exp_q.push_back(model(e, int'(scl), k));
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_block(input logic [BW-1:0] blk, input logic [WE-1:0] scl,
                            input bit use_model, output logic acc_last);
    int n;
    n = 0;
    acc_last = 1'b0;
    i_blk = blk; i_scl = scl; i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 200) break;
    end
    if (o_ready) begin
      acc_last = o_last;
      if (use_model) push_model(blk, scl);
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: o_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_blk   = BW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [RW-1:0] prev_obs;
  logic          prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [RW-1:0] obs;
    logic [RW-1:0] want;
    obs = {o_sgn, o_man, o_exp, o_zero, o_idx, o_last};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_valid) check("stall_hold", obs, prev_obs);
      if (o_valid && !(i_ready && o_last)) check("ready_low_in_emit", o_ready, 0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_elem: got idx %0d with empty expected queue", o_idx);
        end else begin
          want = exp_q.pop_front();
          check("elem", obs, want);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_obs   = obs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc_last;
    logic [BW-1:0] blk;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_man", o_man, 0);
    check("rst_exp", o_exp, 0);
    check("rst_zero", o_zero, 0);
    check("rst_idx", o_idx, 0);
    check("rst_last", o_last, 0);
    check("rst_sgn", o_sgn, 0);
    check("rst_state", o_dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", o_ready, 1);
    check("rel_valid", o_valid, 0);
    @(posedge clk); #1;

    // normalise: {+0011, -1000, +0001, +0110}, scale 10
    i_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 8'hC0, 10'd8,  1'b0, 2'd0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'h80, 10'd10, 1'b0, 2'd1, 1'b0));
    exp_q.push_back(mk(1'b0, 8'h80, 10'd7,  1'b0, 2'd2, 1'b0));
    exp_q.push_back(mk(1'b0, 8'hC0, 10'd9,  1'b0, 2'd3, 1'b1));
    send_block({5'b0_0110, 5'b0_0001, 5'b1_1000, 5'b0_0011}, 8'd10, 1'b0, acc_last);
    @(negedge clk);
    check("norm_first_valid", o_valid, 1);
    check("norm_state_emit", o_dbg_state, 1);
    drain();

    // zero / underflow: {+0000, -0000, +0001, -0101}, scale 0
    exp_q.push_back(mk(1'b0, 8'h00, 10'h000, 1'b1, 2'd0, 1'b0));
    exp_q.push_back(mk(1'b1, 8'h00, 10'h000, 1'b1, 2'd1, 1'b0));
    exp_q.push_back(mk(1'b0, 8'h80, 10'h3FD, 1'b0, 2'd2, 1'b0));
    exp_q.push_back(mk(1'b1, 8'hA0, 10'h3FF, 1'b0, 2'd3, 1'b1));
    send_block({5'b1_0101, 5'b0_0001, 5'b1_0000, 5'b0_0000}, 8'd0, 1'b0, acc_last);
    drain();

    // backpressure: hold i_ready low for 3 cycles while idx 1 is presented
    send_block(BW'($urandom), 8'($urandom), 1'b1, acc_last);
    @(posedge clk); #1;
    i_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_idx", o_idx, 1);
      check("bp_ready", o_ready, 0);
      check("bp_valid", o_valid, 1);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_idx_before_release", o_idx, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idx_after_release", o_idx, 2);
    drain();

    // back-to-back blocks, second accepted on the last-element transfer
    send_block(BW'($urandom), 8'($urandom), 1'b1, acc_last);
    send_block(BW'($urandom), 8'($urandom), 1'b1, acc_last);
    check("b2b_accept_on_last", acc_last, 1);
    @(negedge clk);
    check("b2b_no_bubble", o_valid, 1);
    check("b2b_idx0", o_idx, 0);
    drain();

    // mid-block reset at idx 2
    send_block(BW'($urandom), 8'($urandom), 1'b1, acc_last);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_idx_before_edge", o_idx, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_valid", o_valid, 0);
    check("mrst_ready", o_ready, 0);
    check("mrst_last", o_last, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rel_ready", o_ready, 1);
    check("mrst_rel_valid", o_valid, 0);
    @(posedge clk); #1;
    send_block(BW'($urandom), 8'($urandom), 1'b1, acc_last);
    drain();

    // randomized blocks with random backpressure and gaps
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      blk = BW'($urandom);
      send_block(blk, 8'($urandom_range(0, 255)), 1'b1, acc_last);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
